// File: rtl/spi_packet_rx_if.sv
// SPI pin group and decoded grid-write outputs of the SPI packet receiver.
// The slave modport is the receiver's view; the master modport is the MCU/consumer side.
interface spi_packet_rx_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 6
);
  logic              sck;
  logic              sdi;
  logic              cs;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              pkt_valid;
  logic              frame_err;
  logic [7:0]        err_count;

  modport master (
    output sck, sdi, cs,
    input  waddr, wdata, pkt_valid, frame_err, err_count
  );

  modport slave (
    input  sck, sdi, cs,
    output waddr, wdata, pkt_valid, frame_err, err_count
  );
endinterface

// File: rtl/spi_packet_rx.sv
// SPI mode-0 slave receiver: one fixed-length MSB-first packet per CS window,
// split into a grid address and cell value, with framing-error detection.
module spi_packet_rx #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  spi_packet_rx_if.slave   bus
);

  localparam int PKT   = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(PKT + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PKT);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(PKT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;

  logic              sck_meta_r;
  logic              sck_s_r;
  logic              sck_prev_r;
  logic              sdi_meta_r;
  logic              sdi_s_r;
  logic              cs_meta_r;
  logic              cs_s_r;
  logic              cs_al_r;
  logic              sck_rise_s;

  logic              clear_s;
  logic              shift_s;
  logic              load_s;
  logic              fault_s;

  logic [PKT-1:0]    shreg_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              pkt_valid_r;
  logic              frame_err_r;
  logic [7:0]        err_count_r;

  // Two-flop synchronisers; cs gets one extra stage so it lines up with the
  // sck edge detector (an edge arriving with the cs fall is still accepted).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_meta_r <= 1'b0;
      sck_s_r    <= 1'b0;
      sck_prev_r <= 1'b0;
      sdi_meta_r <= 1'b0;
      sdi_s_r    <= 1'b0;
      cs_meta_r  <= 1'b0;
      cs_s_r     <= 1'b0;
      cs_al_r    <= 1'b0;
    end else begin
      sck_meta_r <= bus.sck;
      sck_s_r    <= sck_meta_r;
      sck_prev_r <= sck_s_r;
      sdi_meta_r <= bus.sdi;
      sdi_s_r    <= sdi_meta_r;
      cs_meta_r  <= bus.cs;
      cs_s_r     <= cs_meta_r;
      cs_al_r    <= cs_s_r;
    end
  end

  // Rising-edge detect on synchronised sck.
  always_comb begin
    sck_rise_s = sck_s_r & ~sck_prev_r;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cs_al_r) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!cs_al_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM output decode: datapath strobes. Holding the shifter clear in IDLE
  // guarantees every packet starts from zero.
  always_comb begin
    clear_s = 1'b0;
    shift_s = 1'b0;
    load_s  = 1'b0;
    fault_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clear_s = 1'b1;
      end
      ST_SHIFT: begin
        shift_s = sck_rise_s;
      end
      ST_DONE: begin
        if (bit_cnt_r == CNT_FULL) begin
          load_s = 1'b1;
        end else begin
          fault_s = 1'b1;
        end
      end
      default: begin
        clear_s = 1'b1;
      end
    endcase
  end

  // Shift register and saturating bit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_r   <= {PKT{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
    end else if (clear_s) begin
      shreg_r   <= {PKT{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
    end else if (shift_s) begin
      shreg_r <= {shreg_r[PKT-2:0], sdi_s_r};
      if (bit_cnt_r != CNT_SAT) begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end else begin
      shreg_r   <= shreg_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Registered packet outputs, one-cycle pulses and saturating error count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waddr_r     <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      pkt_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
      err_count_r <= 8'd0;
    end else begin
      pkt_valid_r <= load_s;
      frame_err_r <= fault_s;
      if (load_s) begin
        waddr_r <= shreg_r[PKT-1:DATA_W];
        wdata_r <= shreg_r[DATA_W-1:0];
      end else begin
        waddr_r <= waddr_r;
        wdata_r <= wdata_r;
      end
      if (fault_s && (err_count_r != 8'hFF)) begin
        err_count_r <= err_count_r + 8'd1;
      end else begin
        err_count_r <= err_count_r;
      end
    end
  end

  assign bus.waddr     = waddr_r;
  assign bus.wdata     = wdata_r;
  assign bus.pkt_valid = pkt_valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.err_count = err_count_r;

endmodule

// File: tb/tb_spi_packet_rx.sv
// Randomised bench for spi_packet_rx: a packet-level model predicts each
// CS window's outcome and the cycle it must appear on, checked every cycle.
module tb_spi_packet_rx;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;

  spi_packet_rx_if #(.ADDR_W(10), .DATA_W(6)) bus ();

  spi_packet_rx #(.ADDR_W(10), .DATA_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int due;
    bit good;
    int val;
  } ev_t;

  ev_t  exp_q[$];
  int   exp_waddr;
  int   exp_wdata;
  int   exp_err;
  int   nbits;
  int   acc;
  int   last_pv_cyc;
  int   last_drop_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total = total + 1;
    if (act !== expv) begin
      bad = bad + 1;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  // Every-cycle comparison against the packet-level model.
  always @(negedge clk) begin
    logic exp_pv;
    logic exp_fe;
    ev_t  ev;
    exp_pv = 1'b0;
    exp_fe = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      ev = exp_q.pop_front();
      if (ev.good) begin
        exp_pv    = 1'b1;
        exp_waddr = (ev.val >> 6) & 32'h3FF;
        exp_wdata = ev.val & 32'h3F;
      end else begin
        exp_fe  = 1'b1;
        exp_err = (exp_err == 255) ? 255 : exp_err + 1;
      end
    end
    if (bus.pkt_valid === 1'b1) last_pv_cyc = cyc;
    chk("pkt_valid", {31'd0, bus.pkt_valid}, {31'd0, exp_pv});
    chk("frame_err", {31'd0, bus.frame_err}, {31'd0, exp_fe});
    chk("waddr", {22'd0, bus.waddr}, exp_waddr);
    chk("wdata", {26'd0, bus.wdata}, exp_wdata);
    chk("err_count", {24'd0, bus.err_count}, exp_err);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_waddr = 0;
    exp_wdata = 0;
    exp_err   = 0;
    nbits     = 0;
    acc       = 0;
  endtask

  task automatic cs_open();
    bus.cs = 1'b1;
    nbits  = 0;
    acc    = 0;
    wait_clk(5);
  endtask

  task automatic clock_bit(input bit b);
    bus.sdi = b;
    wait_clk(4);
    bus.sck = 1'b1;
    wait_clk(4);
    bus.sck = 1'b0;
    nbits = nbits + 1;
    acc   = ((acc << 1) | int'(b)) & 32'h1FFFF;
  endtask

  task automatic cs_close(input int gap);
    ev_t ev;
    wait_clk(3);
    bus.cs        = 1'b0;
    last_drop_cyc = cyc;
    ev.due  = cyc + 5;
    ev.good = (nbits == 16);
    ev.val  = acc & 32'hFFFF;
    exp_q.push_back(ev);
    wait_clk(gap);
  endtask

  task automatic send(input int val, input int n, input int gap);
    cs_open();
    for (int i = n - 1; i >= 0; i--) clock_bit(val[i]);
    cs_close(gap);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    last_pv_cyc   = 0;
    last_drop_cyc = 0;
    model_reset();
    bus.sck = 1'b0;
    bus.sdi = 1'b0;
    bus.cs  = 1'b0;
    reset   = 1'b0;
    wait_clk(3);
    chk("reset_waddr", {22'd0, bus.waddr}, 32'd0);
    chk("reset_pulses", {30'd0, bus.pkt_valid, bus.frame_err}, 32'd0);
    reset = 1'b1;
    wait_clk(3);

    // Good 16-bit packet: address/value split and pulse latency.
    send(32'hA5C3, 16, 8);
    chk("t1_waddr", {22'd0, bus.waddr}, 32'h297);
    chk("t1_wdata", {26'd0, bus.wdata}, 32'h03);
    chk("t1_latency", last_pv_cyc - last_drop_cyc, 32'd5);

    // Short packet.
    send(32'h1234, 15, 8);
    chk("t2_err", {24'd0, bus.err_count}, 32'd1);
    chk("t2_waddr_held", {22'd0, bus.waddr}, 32'h297);

    // Long packet, then a good one.
    send(32'h1FFFF, 17, 8);
    chk("t3_err", {24'd0, bus.err_count}, 32'd2);
    send(32'h0001, 16, 8);
    chk("t3_waddr", {22'd0, bus.waddr}, 32'd0);
    chk("t3_wdata", {26'd0, bus.wdata}, 32'd1);

    // SCK activity with CS low must be ignored.
    for (int i = 0; i < 20; i++) clock_bit(i[0]);
    wait_clk(8);
    chk("t4_err", {24'd0, bus.err_count}, 32'd2);
    chk("t4_wdata", {26'd0, bus.wdata}, 32'd1);

    // Reset mid-packet, released with CS still high.
    cs_open();
    for (int i = 0; i < 8; i++) clock_bit(1'b1);
    reset = 1'b0;
    model_reset();
    wait_clk(3);
    chk("t5_in_reset", {22'd0, bus.waddr} | {24'd0, bus.err_count}, 32'd0);
    reset = 1'b1;
    wait_clk(5);
    for (int i = 0; i < 8; i++) clock_bit(1'b1);
    cs_close(8);
    chk("t5_err", {24'd0, bus.err_count}, 32'd1);

    // Back-to-back packets with minimum CS-low gap.
    send(32'h0001, 16, 4);
    send(32'hFFFF, 16, 8);
    chk("t6_waddr", {22'd0, bus.waddr}, 32'h3FF);
    chk("t6_wdata", {26'd0, bus.wdata}, 32'h3F);

    // Random packets, mostly well-formed.
    for (int k = 0; k < 25; k++) begin
      int n;
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(12, 20)) : 16;
      send(int'($urandom_range(0, 32'h1FFFF)), n, 4 + int'($urandom_range(0, 4)));
    end
    wait_clk(8);

    // Saturation of the error counter.
    for (int k = 0; k < 300; k++) send(int'($urandom_range(0, 1)), 1, 4);
    wait_clk(8);
    chk("t6_err_sat", {24'd0, bus.err_count}, 32'd255);
    chk("pending_events", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
